// File: rtl/cpu_pkg.sv
// Shared definitions between the fetch/issue stage and the control unit.
// Both ends import this package so they agree on the opcode width, where
// the opcode sits in the instruction word, and which opcode ends a program.
package cpu_pkg;

    // Width of the opcode field carried from issue to decode.
    localparam int OPC_W = 6;

    // Default bit position of the opcode field LSB inside an instruction word.
    localparam int OPC_FIELD_LSB = 26;

    // Opcode that terminates the running program.
    localparam logic [OPC_W-1:0] OPC_HALT = 6'h3F;

    // Fetch/issue sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } issue_state_t;

endpackage : cpu_pkg

// File: rtl/opcode_issuer.sv
// Instruction fetch and issue stage.
// Reads instruction words from a synchronous-read memory (data one cycle
// after the enable), holds the word, and offers its opcode to decode under a
// valid/ready handshake. The PC advances by one per accepted instruction,
// can be redirected by execute on the accepting handshake, and a HALT
// opcode parks the stage in DONE until the next start pulse.
module opcode_issuer
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter int               INSTR_W  = 32,
    parameter int               OPC_LSB  = OPC_FIELD_LSB,
    parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_start,
    output logic               io_imem_en,
    output logic [ADDR_W-1:0]  io_imem_addr,
    input  logic [INSTR_W-1:0] io_imem_rdata,
    output logic               io_valid,
    input  logic               io_ready,
    output logic [OPC_W-1:0]   io_opcode,
    output logic [INSTR_W-1:0] io_instr,
    input  logic               io_redirect,
    input  logic [ADDR_W-1:0]  io_redirect_pc,
    output logic [ADDR_W-1:0]  io_pc,
    output logic               io_busy,
    output logic               io_done
);

    issue_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [OPC_W-1:0]   held_opcode;

    // Opcode field of the instruction word currently held for issue.
    assign held_opcode = instr_q[OPC_LSB +: OPC_W];

    // The PC is visible at all times; it is zero after reset and in IDLE.
    assign io_pc = pc_q;

    // State, PC and held instruction registers; reset aborts any transfer at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state, next-PC and output decode for the fetch/issue sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        io_imem_en   = 1'b0;
        io_imem_addr = '0;
        io_valid     = 1'b0;
        io_opcode    = '0;
        io_instr     = '0;
        io_busy      = 1'b0;
        io_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (io_start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                // Present the PC to memory; the word returns next cycle.
                io_busy      = 1'b1;
                io_imem_en   = 1'b1;
                io_imem_addr = pc_q;
                state_d      = WAIT;
            end

            WAIT: begin
                // Read data is valid now; hold it for the whole issue.
                io_busy = 1'b1;
                instr_d = io_imem_rdata;
                state_d = ISSUE;
            end

            ISSUE: begin
                io_busy   = 1'b1;
                io_valid  = 1'b1;
                io_opcode = held_opcode;
                io_instr  = instr_q;
                if (io_ready) begin
                    if (held_opcode == HALT_OPC) begin
                        // HALT is issued, then the stage stops; a redirect
                        // arriving with it is dropped and the PC keeps
                        // pointing at the HALT.
                        state_d = DONE;
                    end else if (io_redirect) begin
                        pc_d    = io_redirect_pc;
                        state_d = FETCH;
                    end else begin
                        // Natural wrap from the top of the address space to 0.
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end

            DONE: begin
                io_done = 1'b1;
                if (io_start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : opcode_issuer
